usb_cdc_tx_scheduler: RTL and testbench



---
 rtl/usb_cdc_pkg.sv | 20 ++
 rtl/usb_cdc_pkt_buf.sv | 25 ++
 rtl/usb_cdc_tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_usb_cdc_tx_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cdc_pkg.sv
// Shared types for the CDC bulk-IN transmit path: scheduler states, data PIDs, packet length.
package usb_cdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_READY,
        ST_SEND,
        ST_WAIT_HS
    } tx_sched_state_e;

    localparam logic PID_DATA0 = 1'b0;
    localparam logic PID_DATA1 = 1'b1;

    localparam int MAX_PKT_DFLT = 64;

    // One extra bit so a full max-size packet length is representable.
    typedef logic [$clog2(MAX_PKT_DFLT):0] pkt_len_t;

endpackage

// File: rtl/usb_cdc_pkt_buf.sv
// Packet retransmit buffer: one write port, combinational read port.
// Contents are don't-care until written, so the array carries no reset.
module usb_cdc_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_dat_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_dat_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_idx_i];

endmodule

// File: rtl/usb_cdc_tx_scheduler.sv
// Drains the TX FIFO into bulk-IN packets, holds each until ACKed, adds ZLPs and tracks DATA0/1.
// Beats stream one per cycle while ep_tready_i is high; the FIFO is popped only while filling the buffer.
module usb_cdc_tx_scheduler
    import usb_cdc_pkg::*;
#(
    parameter int FIFO_DPTH_W = 6,
    parameter int MAX_PKT     = MAX_PKT_DFLT,
    parameter int FLUSH_CYC   = 6000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_ena_i,
    input  logic                   fifo_rempty_i,
    input  logic [FIFO_DPTH_W:0]   fifo_rnum_i,
    output logic                   fifo_rena_o,
    input  logic [7:0]             fifo_rdat_i,
    input  logic                   in_req_i,
    output logic                   nak_o,
    output logic [7:0]             ep_tdata_o,
    output logic                   ep_tvalid_o,
    output logic                   ep_tlast_o,
    output logic                   ep_tempty_o,
    input  logic                   ep_tready_i,
    input  logic                   hs_ack_i,
    input  logic                   hs_fail_i,
    input  logic                   clr_toggle_i,
    output logic                   data_pid_o,
    output logic                   busy_o
);

    localparam int LEN_W = $clog2(MAX_PKT) + 1;
    localparam int IDX_W = $clog2(MAX_PKT);
    localparam int AGE_W = $clog2(FLUSH_CYC + 1);

    tx_sched_state_e  state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             zlp_pend_q, zlp_pend_d;
    logic             pid_q, pid_d;
    logic             nak_q, nak_d;

    logic [31:0]      rnum_ext;
    logic [LEN_W-1:0] len_clip;
    logic             fill_start;
    logic             beat_last;
    logic [7:0]       buf_rdat;

    assign rnum_ext   = 32'(fifo_rnum_i);
    assign fill_start = (state_q == ST_IDLE) && tx_ena_i && !fifo_rempty_i &&
                        ((rnum_ext >= 32'(MAX_PKT)) || (age_q == AGE_W'(FLUSH_CYC)));

    // A non-empty FIFO holds at least one byte even if the count lags behind.
    always_comb begin
        if (rnum_ext >= 32'(MAX_PKT)) begin
            len_clip = LEN_W'(MAX_PKT);
        end else if (rnum_ext == 32'd0) begin
            len_clip = LEN_W'(1);
        end else begin
            len_clip = LEN_W'(rnum_ext);
        end
    end

    assign beat_last   = (len_q == '0) || (idx_q == len_q - LEN_W'(1));

    assign fifo_rena_o = (state_q == ST_FILL);
    assign ep_tvalid_o = (state_q == ST_SEND);
    assign ep_tlast_o  = ep_tvalid_o && beat_last;
    assign ep_tempty_o = ep_tvalid_o && (len_q == '0);
    assign ep_tdata_o  = (ep_tvalid_o && (len_q != '0)) ? buf_rdat : 8'h00;
    assign nak_o       = nak_q;
    assign data_pid_o  = pid_q;
    assign busy_o      = (state_q != ST_IDLE);

    usb_cdc_pkt_buf #(
        .DEPTH (MAX_PKT),
        .IDX_W (IDX_W)
    ) u_pkt_buf (
        .clk_i    (clk_i),
        .wr_en_i  (fifo_rena_o),
        .wr_idx_i (idx_q[IDX_W-1:0]),
        .wr_dat_i (fifo_rdat_i),
        .rd_idx_i (idx_q[IDX_W-1:0]),
        .rd_dat_o (buf_rdat)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        age_d      = '0;
        zlp_pend_d = zlp_pend_q;
        pid_d      = pid_q;
        nak_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_rempty_i) begin
                    age_d = (age_q == AGE_W'(FLUSH_CYC)) ? age_q : age_q + AGE_W'(1);
                end
                if (fill_start) begin
                    len_d   = len_clip;
                    idx_d   = '0;
                    age_d   = '0;
                    state_d = ST_FILL;
                    nak_d   = in_req_i;
                end else if (in_req_i && zlp_pend_q) begin
                    len_d   = '0;
                    idx_d   = '0;
                    age_d   = '0;
                    state_d = ST_SEND;
                end else if (in_req_i) begin
                    nak_d = 1'b1;
                end
            end
            ST_FILL: begin
                nak_d = in_req_i;
                idx_d = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    idx_d   = '0;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (in_req_i) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ep_tready_i) begin
                    if (beat_last) begin
                        idx_d   = '0;
                        state_d = ST_WAIT_HS;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_WAIT_HS: begin
                if (hs_ack_i) begin
                    pid_d      = ~pid_q;
                    zlp_pend_d = (len_q == LEN_W'(MAX_PKT));
                    state_d    = ST_IDLE;
                end else if (hs_fail_i) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr_toggle_i) begin
            pid_d      = PID_DATA0;
            zlp_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            age_q      <= '0;
            zlp_pend_q <= 1'b0;
            pid_q      <= PID_DATA0;
            nak_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            age_q      <= age_d;
            zlp_pend_q <= zlp_pend_d;
            pid_q      <= pid_d;
            nak_q      <= nak_d;
        end
    end

endmodule

// File: tb/tb_usb_cdc_tx_scheduler.sv
// Scoreboard bench for usb_cdc_tx_scheduler: a FIFO model feeds bytes, expected beats are queued per IN token.
module tb_usb_cdc_tx_scheduler;
    import usb_cdc_pkg::*;

    localparam int DW    = 6;
    localparam int MAXP  = 64;
    localparam int FLUSH = 6000;
    localparam int FDEPTH = 1 << DW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          tx_ena_i = 1'b1;
    logic          fifo_rempty_i = 1'b1;
    logic [DW:0]   fifo_rnum_i = '0;
    logic          fifo_rena_o;
    logic [7:0]    fifo_rdat_i = 8'h00;
    logic          in_req_i = 1'b0;
    logic          nak_o;
    logic [7:0]    ep_tdata_o;
    logic          ep_tvalid_o;
    logic          ep_tlast_o;
    logic          ep_tempty_o;
    logic          ep_tready_i = 1'b1;
    logic          hs_ack_i = 1'b0;
    logic          hs_fail_i = 1'b0;
    logic          clr_toggle_i = 1'b0;
    logic          data_pid_o;
    logic          busy_o;

    usb_cdc_tx_scheduler #(
        .FIFO_DPTH_W (DW),
        .MAX_PKT     (MAXP),
        .FLUSH_CYC   (FLUSH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tx_ena_i      (tx_ena_i),
        .fifo_rempty_i (fifo_rempty_i),
        .fifo_rnum_i   (fifo_rnum_i),
        .fifo_rena_o   (fifo_rena_o),
        .fifo_rdat_i   (fifo_rdat_i),
        .in_req_i      (in_req_i),
        .nak_o         (nak_o),
        .ep_tdata_o    (ep_tdata_o),
        .ep_tvalid_o   (ep_tvalid_o),
        .ep_tlast_o    (ep_tlast_o),
        .ep_tempty_o   (ep_tempty_o),
        .ep_tready_i   (ep_tready_i),
        .hs_ack_i      (hs_ack_i),
        .hs_fail_i     (hs_fail_i),
        .clr_toggle_i  (clr_toggle_i),
        .data_pid_o    (data_pid_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] dat;
        logic       last;
        logic       empty;
        logic       pid;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] pend_q[$];
    logic [7:0] mdl_q[$];
    logic [7:0] last_pkt[$];
    int         total = 0;
    int         bad = 0;
    int         pop_cnt = 0;
    int         acc_cnt = 0;
    int         last_len = 0;
    logic       mdl_pid = 1'b0;
    logic       mdl_zlp = 1'b0;
    bit         rdy_rand = 1'b0;
    logic       pop_s;
    beat_t      mon_e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // FIFO model (fall-through) plus the ready driver, updated 1 time unit after each rising edge.
    always begin
        @(posedge clk_i);
        pop_s = fifo_rena_o;
        #1;
        if (pop_s && !rst_i) begin
            chk("pop_on_empty", 32'(fifo_rempty_i), 32'd0);
            if (fq.size() > 0) begin
                void'(fq.pop_front());
                pop_cnt++;
            end
        end
        while (pend_q.size() > 0 && fq.size() < FDEPTH) fq.push_back(pend_q.pop_front());
        fifo_rempty_i = (fq.size() == 0);
        fifo_rnum_i   = (DW+1)'(fq.size());
        fifo_rdat_i   = (fq.size() > 0) ? fq[0] : 8'h00;
        ep_tready_i   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk_i) begin
        if (!rst_i && ep_tempty_o) chk("tempty_gated", {30'd0, ep_tvalid_o, ep_tlast_o}, 32'd3);
        if (!rst_i && ep_tvalid_o && ep_tready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.empty) chk("tdata", 32'(ep_tdata_o), 32'(mon_e.dat));
                chk("tlast", 32'(ep_tlast_o), 32'(mon_e.last));
                chk("tempty", 32'(ep_tempty_o), 32'(mon_e.empty));
                chk("pid", 32'(data_pid_o), 32'(mon_e.pid));
            end
            acc_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            pend_q.push_back(8'(base + i));
            mdl_q.push_back(8'(base + i));
        end
    endtask

    task automatic expect_pkt(input int n);
        beat_t e;
        last_pkt.delete();
        acc_cnt  = 0;
        last_len = n;
        if (n == 0) begin
            e.dat = 8'h00; e.last = 1'b1; e.empty = 1'b1; e.pid = mdl_pid;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < n; i++) begin
                e.dat = mdl_q.pop_front(); e.last = (i == n - 1); e.empty = 1'b0; e.pid = mdl_pid;
                last_pkt.push_back(e.dat);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic expect_retx();
        beat_t e;
        acc_cnt = 0;
        for (int i = 0; i < last_pkt.size(); i++) begin
            e.dat = last_pkt[i]; e.last = (i == last_pkt.size() - 1); e.empty = 1'b0; e.pid = mdl_pid;
            exp_q.push_back(e);
        end
    endtask

    task automatic in_token(input logic exp_nak);
        in_req_i = 1'b1;
        tick();
        in_req_i = 1'b0;
        chk("nak", 32'(nak_o), 32'(exp_nak));
        if (exp_nak) begin
            tick();
            chk("nak_one_cycle", 32'(nak_o), 32'd0);
        end
    endtask

    task automatic wait_drain(input int budget);
        int b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            tick();
            b--;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("busy_wait_hs", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int b = budget;
        while (pop_cnt < target && b > 0) begin
            tick();
            b--;
        end
        chk("pop_count", 32'(pop_cnt), 32'(target));
    endtask

    task automatic ack();
        hs_ack_i = 1'b1;
        tick();
        hs_ack_i = 1'b0;
        mdl_pid = ~mdl_pid;
        mdl_zlp = (last_len == MAXP);
        chk("pid_after_ack", 32'(data_pid_o), 32'(mdl_pid));
    endtask

    task automatic hs_fail();
        hs_fail_i = 1'b1;
        tick();
        hs_fail_i = 1'b0;
    endtask

    task automatic clr_toggle();
        clr_toggle_i = 1'b1;
        tick();
        clr_toggle_i = 1'b0;
        mdl_pid = PID_DATA0;
        mdl_zlp = 1'b0;
        chk("pid_clr", 32'(data_pid_o), 32'd0);
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tvalid", 32'(ep_tvalid_o), 32'd0);
        chk("rst_nak", 32'(nak_o), 32'd0);
        chk("rst_pid", 32'(data_pid_o), 32'd0);
        chk("rst_rena", 32'(fifo_rena_o), 32'd0);
        rst_i = 1'b0;
        tick(2);

        // Short packet flushed only after the idle timeout.
        base = pop_cnt;
        feed(10, 0);
        tick(5900);
        chk("no_early_pop", 32'(pop_cnt), 32'(base));
        wait_pops(base + 10, 400);
        tick();
        expect_pkt(10);
        in_token(1'b0);
        wait_drain(100);
        ack();

        // Full packet, then ZLP, then NAK.
        clr_toggle();
        base = pop_cnt;
        feed(64, 8'h10);
        wait_pops(base + 64, 200);
        tick();
        expect_pkt(64);
        in_token(1'b0);
        wait_drain(200);
        ack();
        chk("zlp_model", 32'(mdl_zlp), 32'd1);
        expect_pkt(0);
        in_token(1'b0);
        wait_drain(20);
        ack();
        in_token(1'b1);

        // Retransmit after handshake failure reuses the buffer.
        clr_toggle();
        base = pop_cnt;
        feed(64, 8'hA0);
        wait_pops(base + 64, 200);
        tick();
        expect_pkt(64);
        in_token(1'b0);
        wait_drain(200);
        hs_fail();
        expect_retx();
        in_token(1'b0);
        wait_drain(200);
        ack();
        chk("retx_pops", 32'(pop_cnt - base), 32'd64);

        // 130 bytes: 64, 64, then a 2-byte flush with no trailing ZLP.
        clr_toggle();
        base = pop_cnt;
        feed(130, 8'h40);
        wait_pops(base + 64, 200);
        tick();
        expect_pkt(64);
        in_token(1'b0);
        wait_drain(200);
        ack();
        wait_pops(base + 128, 200);
        tick();
        expect_pkt(64);
        in_token(1'b0);
        wait_drain(200);
        ack();
        wait_pops(base + 130, 6400);
        tick();
        expect_pkt(2);
        in_token(1'b0);
        wait_drain(50);
        ack();
        in_token(1'b1);

        // NAK during FILL, then reset mid-SEND with ready toggling.
        base = pop_cnt;
        feed(64, 8'hC0);
        wait_pops(base + 5, 50);
        in_token(1'b1);
        wait_pops(base + 64, 200);
        tick();
        rdy_rand = 1'b1;
        expect_pkt(64);
        in_token(1'b0);
        begin
            int b = 500;
            while (acc_cnt < 20 && b > 0) begin
                tick();
                b--;
            end
        end
        chk("beat20", 32'(acc_cnt), 32'd20);
        rst_i = 1'b1;
        #1;
        chk("arst_tvalid", 32'(ep_tvalid_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_pid", 32'(data_pid_o), 32'd0);
        chk("arst_tlast", 32'(ep_tlast_o), 32'd0);
        chk("arst_tempty", 32'(ep_tempty_o), 32'd0);
        chk("arst_tdata", 32'(ep_tdata_o), 32'd0);
        chk("arst_nak", 32'(nak_o), 32'd0);
        exp_q.delete();
        mdl_pid = PID_DATA0;
        mdl_zlp = 1'b0;
        tick(2);
        rst_i = 1'b0;
        rdy_rand = 1'b0;
        tick();
        in_token(1'b1);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
